// File: rtl/add16_core.sv
// 16-bit registered ripple-carry adder built from Nand2Tetris-style half/full adder cells.
// Define ADD16_SATURATE_EN to clamp the sum on signed overflow instead of wrapping.

module add16_half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module add16_full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    logic partialSum;
    logic carryAb;
    logic carryPc;

    add16_half_adder haAb (.a(a),          .b(b), .sum(partialSum), .carry(carryAb));
    add16_half_adder haPc (.a(partialSum), .b(c), .sum(sum),        .carry(carryPc));

    assign carry = carryAb | carryPc;
endmodule

module add16_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             carry_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    logic [WIDTH:0]   carryChain;
    logic [WIDTH-1:0] rawSum;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic             overflow_d;

    logic             valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             overflow_q;
    logic             zero_q;
    logic             negative_q;

    assign carryChain[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        add16_full_adder fa (
            .a    (in_a[i]),
            .b    (in_b[i]),
            .c    (carryChain[i]),
            .sum  (rawSum[i]),
            .carry(carryChain[i+1])
        );
    end

    assign carry_d    = carryChain[WIDTH];
    assign overflow_d = carryChain[WIDTH] ^ carryChain[WIDTH-1];

`ifdef ADD16_SATURATE_EN
    // Overflow only happens with equal operand signs, so in_a's sign picks the rail.
    always_comb begin
        sum_d = rawSum;
        if (overflow_d) begin
            sum_d = in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_d = rawSum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q      <= sum_d;
                carry_q    <= carry_d;
                overflow_q <= overflow_d;
                zero_q     <= (sum_d == '0);
                negative_q <= sum_d[WIDTH-1];
            end
        end
    end

    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign carry_out = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
endmodule

// File: tb/tb_add16_core.sv
// Directed self-checking bench for add16_core; expected values are hand-computed constants.
// Build with ADD16_SATURATE_EN defined to check the clamping variant.

module tb_add16_core;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        carry_in;
    logic        out_valid;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;
    logic        zero;
    logic        negative;

    int total = 0;
    int bad   = 0;

    add16_core #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_a     (in_a),
        .in_b     (in_b),
        .carry_in (carry_in),
        .out_valid(out_valid),
        .sum      (sum),
        .carry_out(carry_out),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {out_valid, carry_out, overflow, zero, negative, sum}
    function automatic logic [20:0] pack(input logic v, input logic c, input logic o,
                                         input logic z, input logic n, input logic [15:0] s);
        return {v, c, o, z, n, s};
    endfunction

    task automatic checkOutput(input string tag, input logic [20:0] expected);
        logic [20:0] observed;
        observed = pack(out_valid, carry_out, overflow, zero, negative, sum);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed v/c/o/z/n/sum=%b%b%b%b%b/%h expected=%b%b%b%b%b/%h",
                   tag, observed[20], observed[19], observed[18], observed[17], observed[16],
                   observed[15:0], expected[20], expected[19], expected[18], expected[17],
                   expected[16], expected[15:0]);
        end
    endtask

    // Drive one operand set and sample 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        carry_in = cin;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a     = 16'h0000;
        in_b     = 16'h0000;
        carry_in = 1'b0;
        $display("[TB] starting add16_core directed test");

        #2;
        checkOutput("reset_state", pack(0, 0, 0, 0, 0, 16'h0000));
        @(posedge clk);
        #1;
        checkOutput("reset_held", pack(0, 0, 0, 0, 0, 16'h0000));
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1, 16'd14, 16'd59, 0);
        checkOutput("pos_add", pack(1, 0, 0, 0, 0, 16'h0049));

        applyStimulus(1, 16'd14, 16'hFFC5, 0);
        checkOutput("mixed_sign", pack(1, 0, 0, 0, 1, 16'hFFD3));

        applyStimulus(1, 16'hFFF2, 16'hFFC5, 0);
        checkOutput("both_neg", pack(1, 1, 0, 0, 1, 16'hFFB7));

        applyStimulus(1, 16'h7FFF, 16'h0001, 0);
`ifdef ADD16_SATURATE_EN
        checkOutput("pos_ovf", pack(1, 0, 1, 0, 0, 16'h7FFF));
`else
        checkOutput("pos_ovf", pack(1, 0, 1, 0, 1, 16'h8000));
`endif

        applyStimulus(1, 16'h8000, 16'h8000, 0);
`ifdef ADD16_SATURATE_EN
        checkOutput("neg_ovf_min", pack(1, 1, 1, 0, 1, 16'h8000));
`else
        checkOutput("neg_ovf_min", pack(1, 1, 1, 1, 0, 16'h0000));
`endif

        applyStimulus(1, 16'h8000, 16'hFFFF, 0);
`ifdef ADD16_SATURATE_EN
        checkOutput("neg_ovf", pack(1, 1, 1, 0, 1, 16'h8000));
`else
        checkOutput("neg_ovf", pack(1, 1, 1, 0, 0, 16'h7FFF));
`endif

        applyStimulus(1, 16'hFFFF, 16'h0000, 1);
        checkOutput("carry_in_wrap", pack(1, 1, 0, 1, 0, 16'h0000));

        applyStimulus(1, 16'hFFFF, 16'h0001, 0);
        checkOutput("ffff_plus_1", pack(1, 1, 0, 1, 0, 16'h0000));

        applyStimulus(1, 16'h00FF, 16'h0000, 1);
        checkOutput("carry_in_ripple", pack(1, 0, 0, 0, 0, 16'h0100));

        applyStimulus(1, 16'h0001, 16'h0001, 0);
        checkOutput("b2b_0", pack(1, 0, 0, 0, 0, 16'h0002));
        applyStimulus(1, 16'd100, 16'd200, 0);
        checkOutput("b2b_1", pack(1, 0, 0, 0, 0, 16'h012C));
        applyStimulus(1, 16'h1234, 16'h4321, 0);
        checkOutput("b2b_2", pack(1, 0, 0, 0, 0, 16'h5555));
        applyStimulus(0, 16'hAAAA, 16'h5555, 1);
        checkOutput("hold_0", pack(0, 0, 0, 0, 0, 16'h5555));
        applyStimulus(0, 16'hFFFF, 16'h0001, 0);
        checkOutput("hold_1", pack(0, 0, 0, 0, 0, 16'h5555));

        applyStimulus(1, 16'h0005, 16'h0006, 0);
        checkOutput("pre_reset", pack(1, 0, 0, 0, 0, 16'h000B));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", pack(0, 0, 0, 0, 0, 16'h0000));
        in_a = 16'h0010;
        in_b = 16'h0020;
        @(posedge clk);
        #1;
        checkOutput("reset_discard", pack(0, 0, 0, 0, 0, 16'h0000));
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1, 16'h0001, 16'h0002, 0);
        checkOutput("post_reset", pack(1, 0, 0, 0, 0, 16'h0003));
        applyStimulus(0, 16'h0000, 16'h0000, 0);
        checkOutput("post_reset_idle", pack(0, 0, 0, 0, 0, 16'h0003));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/add16_core.md
Name: add16_core

Overview:
- 16-bit two's-complement adder, registered output; the arithmetic primitive under the Hack ALU datapath.
- Operands are added through a chain of 16 full-adder cells with a ripple carry, built from half adders in the Nand2Tetris gate style. No behavioural `+` operator is used.
- Result and status flags are captured in one output register stage, qualified by a valid strobe.

Parameters:
- WIDTH, 16, operand/result width; only 16 is supported, the parameter exists for clarity of port declarations.

Ports:
- clk        input   1      single system clock, rising-edge active
- rst_n      input   1      asynchronous active-low reset
- in_valid   input   1      operands on in_a/in_b are valid this cycle
- in_a       input   16     operand A, two's complement
- in_b       input   16     operand B, two's complement
- carry_in   input   1      carry into bit 0 (0 for plain add)
- out_valid  output  1      sum/flags hold a new result
- sum        output  16     registered in_a + in_b + carry_in, modulo 2^16
- carry_out  output  1      unsigned carry out of bit 15
- overflow   output  1      signed overflow
- zero       output  1      sum == 0
- negative   output  1      sum[15]

Behaviour:
- Reset: while rst_n=0, all outputs are forced low asynchronously: out_valid=0, sum=16'h0000, carry_out=0, overflow=0, zero=0, negative=0. Release is synchronous to clk in effect; the first capture happens on the first rising edge with rst_n=1.
- Datapath: the combinational ripple chain covers bits 0..15. Bit i uses a full adder producing s[i] and c[i+1], with c[0]=carry_in.
- Latency: exactly 1 cycle. If in_valid=1 at edge N, the result is visible after edge N and out_valid=1 for that cycle.
- Hold: when in_valid=0 at an edge, sum and flags hold their previous values and out_valid=0.
- Throughput: back-to-back operation, one result per cycle; there is no backpressure.
- Width rules:
  - sum is truncated to 16 bits.
  - carry_out = c[16].
  - overflow = c[16] XOR c[15], i.e. both operands have the same sign and the result sign differs.
  - zero and negative are derived from the truncated 16-bit sum.
- Boundary conditions:
  - 16'hFFFF + 16'h0001: sum=0, carry_out=1, zero=1, overflow=0.
  - 16'h7FFF + 16'h0001: sum=16'h8000, overflow=1, negative=1.
  - 16'h8000 + 16'h8000: sum=0, carry_out=1, overflow=1, zero=1.
- Reset mid-operation: an in-flight result is discarded, the outputs go to their reset values immediately, and no result is produced for the operand present during reset.

Optional Feature:
- Macro ADD16_SATURATE_EN.
- When defined:
  - On signed overflow, sum clamps to 16'h7FFF if both operands are non-negative, else 16'h8000.
  - overflow still reports 1, and zero/negative reflect the clamped value.
  - carry_out is unchanged (raw c[16]).
  - The clamp is applied before the output register, so latency stays 1 cycle.
- When undefined: wrap-around modulo 2^16 as specified above, and no clamp logic is synthesized.

Test Plan:
- Positive add: in_a=14, in_b=59, carry_in=0, in_valid=1 → next cycle sum=73 (16'h0049), out_valid=1, carry_out=0, overflow=0, zero=0, negative=0.
- Mixed signs: in_a=14, in_b=-59 (16'hFFC5) → sum=-45 (16'hFFD3), negative=1, carry_out=0, overflow=0.
- Both negative: in_a=-14 (16'hFFF2), in_b=-59 → sum=-73 (16'hFFB7), carry_out=1, overflow=0, negative=1.
- Overflow and wrap: 16'h7FFF+16'h0001 → sum=16'h8000 and overflow=1 without the macro; 16'h7FFF with ADD16_SATURATE_EN. Separately, 16'hFFFF+16'h0000 with carry_in=1 → sum=0, zero=1, carry_out=1.
- Valid/hold: issue 3 back-to-back operands, then drop in_valid → 3 consecutive out_valid pulses with correct sums, then out_valid=0 while sum holds the last value.
- Async reset: assert rst_n=0 between clock edges with out_valid=1 → all outputs go to 0 before the next edge. Release reset, apply 1+2 → sum=3 one cycle later.
